// File: rtl/zhang_cnn_acc_requant.sv
// Bias-seeded saturating accumulator with round/shift/clip/ReLU requantization.
// Latency 2 cycles from the last beat to out_valid; in_ready drops only when both SUM and OUT are full and OUT is stalled.
module zhang_cnn_acc_requant #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int OUT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [31:0]      bias,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             acc_ovf
);

  localparam logic [ACC_W-1:0] L_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] L_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] L_OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] L_OUT_MIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic             r_run;
  logic             r_in_win;
  logic [ACC_W-1:0] r_acc;
  logic [4:0]       r_shift;
  logic             r_relu;
  logic             r_sum_vld;
  logic [ACC_W-1:0] r_sum;
  logic [4:0]       r_sum_shift;
  logic             r_sum_relu;
  logic             r_out_vld;
  logic [OUT_W-1:0] r_out_dat;
  logic             r_ovf;

  logic                    w_fire;
  logic                    w_adv;
  logic [ACC_W:0]          w_base;
  logic [ACC_W:0]          w_dat_x;
  logic [ACC_W:0]          w_add;
  logic                    w_ovf;
  logic [ACC_W-1:0]        w_acc_nxt;
  logic [4:0]              w_shift;
  logic                    w_relu;
  logic [ACC_W:0]          w_half;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic [OUT_W-1:0]        w_clip;
  logic [OUT_W-1:0]        w_req;

  assign in_ready  = r_run && (!r_sum_vld || !r_out_vld || out_ready);
  assign w_fire    = in_valid && in_ready;
  assign w_adv     = r_sum_vld && (!r_out_vld || out_ready);
  assign out_data  = r_out_dat;
  assign out_valid = r_out_vld;
  assign acc_ovf   = r_ovf;

  // The first beat of a window seeds from bias and takes the live config.
  assign w_base  = r_in_win ? {r_acc[ACC_W-1], r_acc}
                            : {{(ACC_W+1-32){bias[31]}}, bias};
  assign w_shift = r_in_win ? r_shift : shift;
  assign w_relu  = r_in_win ? r_relu  : relu_en;
  assign w_dat_x = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_add   = w_base + w_dat_x;
  assign w_ovf   = w_add[ACC_W] ^ w_add[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_add[ACC_W-1:0];
    if (w_ovf) w_acc_nxt = w_add[ACC_W] ? L_ACC_MIN : L_ACC_MAX;
  end

  // One guard bit keeps the round-half-up add from wrapping at the accumulator limit.
  assign w_half = (r_sum_shift == 5'd0) ? '0
                : ({{ACC_W{1'b0}}, 1'b1} << (r_sum_shift - 5'd1));
  assign w_rnd  = $signed({r_sum[ACC_W-1], r_sum} + w_half);
  assign w_shr  = w_rnd >>> r_sum_shift;

  always_comb begin
    w_clip = w_shr[OUT_W-1:0];
    if (w_shr > L_OUT_MAX)      w_clip = L_OUT_MAX[OUT_W-1:0];
    else if (w_shr < L_OUT_MIN) w_clip = L_OUT_MIN[OUT_W-1:0];
    w_req = w_clip;
    if (r_sum_relu && w_clip[OUT_W-1]) w_req = '0;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_run       <= 1'b0;
      r_in_win    <= 1'b0;
      r_acc       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_sum_vld   <= 1'b0;
      r_sum       <= '0;
      r_sum_shift <= '0;
      r_sum_relu  <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_fire) begin
        r_ovf <= r_ovf | w_ovf;
        if (in_last) begin
          r_sum       <= w_acc_nxt;
          r_sum_shift <= w_shift;
          r_sum_relu  <= w_relu;
          r_acc       <= '0;
          r_in_win    <= 1'b0;
        end else begin
          r_acc    <= w_acc_nxt;
          r_shift  <= w_shift;
          r_relu   <= w_relu;
          r_in_win <= 1'b1;
        end
      end
      if (w_fire && in_last) r_sum_vld <= 1'b1;
      else if (w_adv)        r_sum_vld <= 1'b0;
      if (w_adv) begin
        r_out_dat <= w_req;
        r_out_vld <= 1'b1;
      end else if (out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zhang_cnn_acc_requant.sv
// Randomized and directed bench for zhang_cnn_acc_requant against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_zhang_cnn_acc_requant;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] bias = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        acc_ovf;

  int     errs = 0;
  int     checks = 0;
  int     rdy_mode = 0;
  longint exp_q[$];
  longint win_q[$];

  localparam int BOUND = 200;

  zhang_cnn_acc_requant dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .bias(bias), .shift(shift), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc_ovf(acc_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Saturating accumulation of bias and window beats, then round/shift/clip/ReLU.
  function automatic longint ref_model(input longint b, input int sh, input bit rl);
    longint acc;
    longint amax;
    longint amin;
    amax = (64'sd1 <<< 39) - 1;
    amin = -(64'sd1 <<< 39);
    acc = b;
    foreach (win_q[i]) begin
      acc = acc + win_q[i];
      if (acc > amax) acc = amax;
      else if (acc < amin) acc = amin;
    end
    if (sh > 0) acc = acc + (64'sd1 <<< (sh - 1));
    acc = acc >>> sh;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (rl && acc < 0) acc = 0;
    return acc;
  endfunction

  always begin
    @(negedge ap_clk);
    if (rdy_mode == 2) out_ready = ($urandom_range(3) != 0);
    else               out_ready = rdy_mode[0];
  end

  // Output monitor: pre-edge sampling of handshakes and stall stability.
  initial begin
    bit          stall;
    logic [15:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge ap_clk);
      #4;
      if (!ap_rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_vld", out_valid, 1);
          chk("hold_dat", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
          else chk("out_data", longint'($signed(out_data)), exp_q.pop_front());
        end
        stall = out_valid && !out_ready;
        held  = out_data;
      end
    end
  end

  task automatic idle_cycle();
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
    bias     = $urandom;
    shift    = 5'($urandom);
    relu_en  = 1'($urandom);
  endtask

  task automatic send_beat(input longint d, input bit last, input longint b, input int sh, input bit rl);
    int n;
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = d[31:0];
    in_last  = last;
    bias     = b[31:0];
    shift    = sh[4:0];
    relu_en  = rl;
    #4;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(negedge ap_clk);
      #4;
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge ap_clk);
  endtask

  // Sends win_q; config is only meaningful on the first beat, later beats carry junk.
  task automatic send_window(input longint b, input int sh, input bit rl, input bit with_last, input int gapmax);
    for (int i = 0; i < win_q.size(); i++) begin
      repeat ($urandom_range(gapmax)) idle_cycle();
      if (i == 0) send_beat(win_q[i], with_last && (win_q.size() == 1), b, sh, rl);
      else send_beat(win_q[i], with_last && (i == win_q.size() - 1),
                     longint'($signed($urandom)), int'($urandom_range(31)), 1'($urandom));
    end
  endtask

  task automatic single(input longint d, input longint b, input int sh, input bit rl, input longint exp);
    win_q = '{d};
    exp_q.push_back(exp);
    send_window(b, sh, rl, 1'b1, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      idle_cycle();
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) idle_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    realtime t0;
    realtime t1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge ap_clk);
    #1 ap_rst_n = 1'b1;
    rdy_mode = 1;
    repeat (2) idle_cycle();

    // Basic window and 2-cycle latency
    win_q = '{100, 200, 300};
    exp_q.push_back(600);
    send_window(0, 0, 1'b0, 1'b1, 0);
    @(negedge ap_clk);
    in_valid = 1'b0;
    #1 chk("lat_n_plus_0", out_valid, 0);
    @(negedge ap_clk);
    #1 chk("lat_n_plus_1", out_valid, 1);
    chk("lat_data", longint'($signed(out_data)), 600);
    @(negedge ap_clk);
    #1 chk("lat_one_cycle", out_valid, 0);
    drain();

    // Rounding, ReLU and output saturation
    single(6, 0, 2, 1'b0, 2);
    single(-7, 0, 1, 1'b0, -3);
    single(5, -10, 0, 1'b1, 0);
    single(64'sh7FFFFFFF, 0, 0, 1'b0, 32767);
    single(-64'sh80000000, 0, 0, 1'b0, -32768);
    drain();
    chk("ovf_after_out_sat", acc_ovf, 0);

    // Back-to-back single-beat windows at full rate
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    win_q = '{1};
    send_window(0, 0, 1'b0, 1'b1, 0);
    t0 = $realtime;
    win_q = '{2}; send_window(0, 0, 1'b0, 1'b1, 0);
    win_q = '{3}; send_window(0, 0, 1'b0, 1'b1, 0);
    win_q = '{4}; send_window(0, 0, 1'b0, 1'b1, 0);
    t1 = $realtime;
    chk("throughput_cycles", longint'((t1 - t0) / 10.0), 3);
    drain();

    // Backpressure: OUT holds 1, SUM holds 2, beat 3 stalls
    rdy_mode = 0;
    repeat (2) idle_cycle();
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    win_q = '{1}; send_window(0, 0, 1'b0, 1'b1, 0);
    win_q = '{2}; send_window(0, 0, 1'b0, 1'b1, 0);
    fork
      send_beat(3, 1'b1, 0, 0, 1'b0);
      begin
        @(negedge ap_clk);
        #4;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data", longint'($signed(out_data)), 1);
        repeat (3) @(negedge ap_clk);
        #4 chk("bp_still_stalled", in_ready, 0);
        rdy_mode = 1;
      end
    join
    drain();

    // Randomized windows against the reference model
    rdy_mode = 2;
    for (int w = 0; w < 80; w++) begin
      longint b;
      int     sh;
      bit     rl;
      int     nb;
      win_q.delete();
      nb = (w % 5 == 0) ? 1 : int'($urandom_range(1, 6));
      for (int k = 0; k < nb; k++) win_q.push_back(longint'($signed($urandom)));
      b  = longint'($signed($urandom));
      sh = int'($urandom_range(31));
      rl = 1'($urandom);
      exp_q.push_back(ref_model(b, sh, rl));
      send_window(b, sh, rl, 1'b1, 2);
    end
    rdy_mode = 1;
    drain();
    chk("ovf_after_random", acc_ovf, 0);

    // Accumulator overflow pins at 2^39-1; shift 25 exposes the pinned value
    win_q.delete();
    for (int k = 0; k < 300; k++) win_q.push_back(64'sh7FFFFFFF);
    exp_q.push_back(32767);
    send_window(0, 0, 1'b0, 1'b1, 0);
    exp_q.push_back(16384);
    send_window(0, 25, 1'b0, 1'b1, 0);
    drain();
    chk("ovf_set", acc_ovf, 1);
    single(9, 0, 0, 1'b0, 9);
    drain();
    chk("ovf_sticky", acc_ovf, 1);

    // Reset mid-window discards the partial sum
    win_q = '{50, 60};
    send_window(0, 0, 1'b0, 1'b0, 0);
    @(negedge ap_clk);
    in_valid = 1'b0;
    #1 ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_acc_ovf", acc_ovf, 0);
    repeat (2) @(negedge ap_clk);
    #1 ap_rst_n = 1'b1;
    single(7, 0, 0, 1'b0, 7);
    drain();
    chk("ovf_after_reset", acc_ovf, 0);

    in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/zhang_cnn_acc_requant.md
ZHANG_CNN_ACC_REQUANT -- requirements
Module: zhang_cnn_acc_requant

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning width of the signed product input from the 16s x 16s multiplier.
REQ-002 SHALL have parameter ACC_W, default 40, meaning width of the signed accumulator (8 guard bits).
REQ-003 SHALL have parameter OUT_W, default 16, meaning width of the signed requantized output.
REQ-004 SHALL have port ap_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, IN_W, the signed product.
REQ-007 SHALL have port in_valid, input, 1, in_data valid.
REQ-008 SHALL have port in_last, input, 1, marks the final product of an accumulation window.
REQ-009 SHALL have port in_ready, output, 1, the block accepts a beat when in_valid && in_ready.
REQ-010 SHALL have port bias, input, 32, the signed bias added once per window.
REQ-011 SHALL have port shift, input, 5, the right-shift amount 0..31.
REQ-012 SHALL have port relu_en, input, 1, clamps negative results to 0.
REQ-013 SHALL have port out_data, output, OUT_W, the signed requantized result.
REQ-014 SHALL have port out_valid, output, 1, out_data valid.
REQ-015 SHALL have port out_ready, input, 1, the consumer accepts when out_valid && out_ready.
REQ-016 SHALL have port acc_ovf, output, 1, sticky flag set when accumulator saturation occurs.

Function
REQ-017 SHALL sample bias, shift and relu_en on the first accepted beat of each window and hold them until that window's result leaves the SUM stage.
REQ-018 SHALL sign-extend in_data to ACC_W and add it to the accumulator on every accepted beat.
REQ-019 SHALL start each window's accumulator from sign-extended bias; a single-beat window yields bias + in_data.
REQ-020 SHALL saturate the accumulator to the ACC_W signed bounds rather than wrap, and SHALL set acc_ovf when saturation occurs.
REQ-021 SHALL, on an accepted beat with in_last=1, load the final sum and its config into the SUM stage register (sum_valid=1) and clear the accumulator to idle in the same cycle.
REQ-022 SHALL compute in the SUM to OUT transfer: r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (round half up, arithmetic), then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then apply relu_en (negative -> 0).
REQ-023 SHALL advance SUM to OUT when sum_valid && (!out_valid || out_ready).
REQ-024 SHALL drive in_ready = !sum_valid || !out_valid || out_ready. All beats stall while the SUM stage is full and cannot drain.
REQ-025 SHALL give 2-cycle latency: a last beat accepted at edge N produces out_valid=1 after edge N+1 when OUT is free.
REQ-026 SHALL sustain one beat per cycle with out_ready=1, including back-to-back single-beat windows.
REQ-027 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-028 SHALL compute the rounding add at ACC_W+1 bits so the rounding add cannot overflow.
REQ-029 SHALL ignore in_data, in_last and config when in_valid=0 or in_ready=0.

Reset
REQ-030 SHALL, while ap_rst_n=0 (asynchronous assert): out_valid=0, out_data=0, acc_ovf=0, sum_valid=0, accumulator idle/0, in_ready=0.
REQ-031 SHALL, after ap_rst_n rises: in_ready=1 from the first edge; a window partly accumulated at reset is discarded entirely.
REQ-032 SHALL clear acc_ovf only by reset.

Verification
REQ-033 Basic: bias=0, shift=0, relu_en=0, beats 100, 200, 300(last), out_ready=1 -> out_data=600, out_valid 2 cycles after the last beat, for 1 cycle.
REQ-034 Rounding: single beat 6 shift=2 -> 2; single beat -7 shift=1 -> -3; 5 with bias=-10, shift=0, relu_en=1 -> 0.
REQ-035 Saturation: single beat 0x7FFFFFFF, shift=0 -> 32767; 0x80000000 -> -32768; acc_ovf stays 0.
REQ-036 Backpressure: out_ready=0, windows {1(last)}, {2(last)}, then beat 3 -> out holds 1, SUM holds 2, in_ready=0 at beat 3; raising out_ready delivers 1, 2, 3 in order with no loss or duplication.
REQ-037 Accumulator overflow: 300 beats of 0x7FFFFFFF -> accumulator pins at 2^39-1, acc_ovf=1 sticky, out_data=32767.
REQ-038 Reset mid-window: beats 50, 60, assert ap_rst_n low, release, then single beat 7(last) -> out_data=7, no output for the aborted window.
